// File: rtl/conv_share_pkg.sv
// Shared types and constants for the shared excess-3 converter arbiter.
// State encoding plus code width, excess-3 offset and error code.
package conv_share_pkg;

   localparam int         CODE_W     = 4;
   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] ERR_CODE   = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/xs3_conv_core.sv
// Combinational BCD to excess-3 converter.
// Optional non-BCD detection enabled by macro CONV_BCD_CHECK_EN.
import conv_share_pkg::*;

module xs3_conv_core (
   input  logic [CODE_W-1:0] code_i,
   output logic [CODE_W-1:0] xs3_o,
   output logic              err_o
);

   // add the excess-3 offset; flag codes above 9 when checking is built in
   always_comb begin
      xs3_o = code_i + XS3_OFFSET;
      err_o = 1'b0;
`ifdef CONV_BCD_CHECK_EN
      if (code_i > 4'd9) begin
         xs3_o = ERR_CODE;
         err_o = 1'b1;
      end
`else
`endif
   end

endmodule

// File: rtl/conv_share_arbiter.sv
// Round-robin arbiter sharing one excess-3 converter among N_REQ requesters.
// Build option CONV_BCD_CHECK_EN (in xs3_conv_core) reports non-BCD codes.
import conv_share_pkg::*;

module conv_share_arbiter #(
   parameter int N_REQ    = 4,
   parameter int ID_W     = 2,
   parameter int CONV_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [CODE_W*N_REQ-1:0] req_code,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [CODE_W-1:0]       rsp_code,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    rsp_err
);

   localparam logic [2:0] LAT_LAST = 3'(CONV_LAT - 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [2:0]        lat_cnt_q, lat_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [CODE_W-1:0] rsp_code_q, rsp_code_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_err_q, rsp_err_d;

   logic              pick_hit;
   logic [ID_W-1:0]   pick_idx;
   logic [N_REQ-1:0]  grant;
   logic [CODE_W-1:0] conv_res;
   logic              conv_err;
   int                idx;

   xs3_conv_core u_core (
      .code_i (code_q),
      .xs3_o  (conv_res),
      .err_o  (conv_err)
   );

   // round-robin search starting just after the last served requester
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = '0;
      idx      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!pick_hit && req_valid[idx]) begin
            pick_hit = 1'b1;
            pick_idx = ID_W'(idx);
         end
      end
   end

   // next-state, grant and response register updates
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      code_d      = code_q;
      id_d        = id_q;
      lat_cnt_d   = lat_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_code_d  = rsp_code_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      grant       = '0;
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               grant[pick_idx] = 1'b1;
               code_d    = req_code[int'(pick_idx)*CODE_W +: CODE_W];
               id_d      = pick_idx;
               rr_ptr_d  = pick_idx;
               lat_cnt_d = '0;
               state_d   = CONV;
            end
         end
         CONV: begin
            if (lat_cnt_q == LAT_LAST) begin
               rsp_code_d  = conv_res;
               rsp_err_d   = conv_err;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= ID_W'(N_REQ - 1);
         code_q      <= '0;
         id_q        <= '0;
         lat_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= '0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         code_q      <= code_d;
         id_q        <= id_d;
         lat_cnt_q   <= lat_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_code_q  <= rsp_code_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = rst_n ? grant : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_code  = rsp_code_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_conv_share_arbiter.sv
// Self-checking bench for conv_share_arbiter with a behavioural model.
// Honours CONV_BCD_CHECK_EN in its expected values.
module tb_conv_share_arbiter;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [4*N-1:0] req_code;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [3:0]     rsp_code;
   logic [IW-1:0]  rsp_id;
   logic           rsp_err;

   int checks   = 0;
   int failures = 0;
   int last_srv = N - 1;

   conv_share_arbiter #(
      .N_REQ    (N),
      .ID_W     (IW),
      .CONV_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_code  (req_code),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_code  (rsp_code),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_code(input logic [3:0] c);
`ifdef CONV_BCD_CHECK_EN
      if (c > 4'd9) return 4'hF;
`endif
      return 4'((int'(c) + 3) % 16);
   endfunction

   function automatic logic exp_err(input logic [3:0] c);
`ifdef CONV_BCD_CHECK_EN
      return c > 4'd9;
`else
      return (c > 4'd9) && 1'b0;
`endif
   endfunction

   function automatic int model_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int p);
      logic [N-1:0] g;
      g = '0;
      if (p >= 0) g[p] = 1'b1;
      return g;
   endfunction

   function automatic logic [4*N-1:0] rand_codes();
      logic [4*N-1:0] c;
      for (int i = 0; i < N; i++) c[4*i +: 4] = 4'($urandom_range(0, 15));
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n    = 1'b1;
      last_srv = N - 1;
   endtask

   task automatic serve_one(input logic [N-1:0] vld,
                            input logic [4*N-1:0] codes,
                            input int bp);
      int         p;
      logic [3:0] ec;
      logic       ee;
      p = model_pick(vld, last_srv);
      req_valid = vld;
      req_code  = codes;
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== onehot(p)) begin
         failures++;
         $display("FAIL grant: got %b want %b", req_ready, onehot(p));
      end
      if (p >= 0) begin
         ec = exp_code(codes[4*p +: 4]);
         ee = exp_err(codes[4*p +: 4]);
         step();
         checks++;
         if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL conv_start: ready=%b valid=%b want 0/0",
                     req_ready, rsp_valid);
         end
         for (int k = 1; k < LAT; k++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
               failures++;
               $display("FAIL early_rsp: valid=%b at cycle %0d want 0",
                        rsp_valid, k);
            end
         end
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_code !== ec ||
             rsp_id !== IW'(p) || rsp_err !== ee) begin
            failures++;
            $display("FAIL rsp: v=%b code=%0d id=%0d err=%b want 1/%0d/%0d/%b",
                     rsp_valid, rsp_code, rsp_id, rsp_err, ec, p, ee);
         end
         for (int b = 0; b < bp; b++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_code !== ec ||
                rsp_id !== IW'(p) || req_ready !== '0) begin
               failures++;
               $display("FAIL hold: v=%b code=%0d id=%0d rdy=%b want 1/%0d/%0d/0",
                        rsp_valid, rsp_code, rsp_id, req_ready, ec, p);
            end
         end
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         checks++;
         if (rsp_valid !== 1'b0 || rsp_code !== ec || rsp_id !== IW'(p)) begin
            failures++;
            $display("FAIL release: v=%b code=%0d id=%0d want 0/%0d/%0d",
                     rsp_valid, rsp_code, rsp_id, ec, p);
         end
         last_srv = p;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      req_code  = rand_codes();
      rsp_ready = 1'b1;
      step();
      step();
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_code !== 4'd0 ||
          rsp_id !== '0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset: rdy=%b v=%b code=%0d id=%0d err=%b want all 0",
                  req_ready, rsp_valid, rsp_code, rsp_id, rsp_err);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL first_grant: got %b want 0001", req_ready);
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic [4*N-1:0] c;
      c = rand_codes();
      c[11:8] = 4'd5;
      serve_one(4'b0100, c, 0);
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int r = 0; r < 5; r++)
         serve_one(4'b1111, {4'd9, 4'd2, 4'd1, 4'd0}, 0);
   endtask

   task automatic test_backpressure();
      serve_one(4'b1010, rand_codes(), 5);
      serve_one(4'b1010, rand_codes(), 5);
   endtask

   task automatic test_invalid_bcd();
      logic [4*N-1:0] c;
      c = rand_codes();
      c[3:0] = 4'd12;
      serve_one(4'b0001, c, 0);
      c[3:0] = 4'd13;
      serve_one(4'b0001, c, 0);
      for (int v = 0; v < 16; v++) begin
         c = rand_codes();
         for (int i = 0; i < N; i++) c[4*i +: 4] = 4'(v);
         serve_one(N'($urandom_range(1, 15)), c, 0);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++)
         serve_one(N'($urandom_range(1, 15)), rand_codes(),
                   int'($urandom_range(0, 3)));
   endtask

   task automatic test_mid_reset();
      apply_reset();
      serve_one(4'b0001, rand_codes(), 0);
      req_valid = 4'b0110;
      req_code  = rand_codes();
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL mid_grant: got %b want 0010", req_ready);
      end
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 ||
          rsp_code !== 4'd0 || rsp_id !== '0) begin
         failures++;
         $display("FAIL mid_reset: rdy=%b v=%b code=%0d id=%0d want all 0",
                  req_ready, rsp_valid, rsp_code, rsp_id);
      end
      for (int k = 0; k < LAT + 2; k++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL discard: v=%b want 0", rsp_valid);
         end
      end
      rst_n    = 1'b1;
      last_srv = N - 1;
      serve_one(4'b0110, req_code, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_code  = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_invalid_bcd();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
